// File: rtl/cdclib_lvlsync_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cdclib_lvlsync_pkg : parameter limits and helpers for the filtered level sync
// Rev 1.0
// ---------------------------------------------------------------------------
package cdclib_lvlsync_pkg;

  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;
  localparam int FILT_MIN = 1;
  localparam int FILT_MAX = 255;

  // Holds 0..FILT_CNT, so the stability counter can never wrap.
  function automatic int cnt_width(input int filt_cnt);
    return $clog2(filt_cnt + 1);
  endfunction

  function automatic logic inactive_level(input int active_level);
    return (active_level == 0) ? 1'b1 : 1'b0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdclib_lvlsync_filt_ch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cdclib_lvlsync_filt_ch : one channel - sync chain, stability filter, strobes.
// Optional sticky change flag under CDCLIB_LVLSYNC_STICKY_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module cdclib_lvlsync_filt_ch
  import cdclib_lvlsync_pkg::*;
#(
  parameter int SYNCSTAGE     = 2,
  parameter int FILT_CNT      = 4,
  parameter int ACTIVE_LEVEL  = 1,
  parameter int EN_PULSE_MODE = 0
) (
  input  logic rd_clk,
  input  logic rd_rst_n,
  input  logic data_in,
`ifdef CDCLIB_LVLSYNC_STICKY_EN
  input  logic sticky_clr,
  output logic chg_sticky,
`endif
  output logic data_out,
  output logic data_lvl,
  output logic rise_pls,
  output logic fall_pls
);

  localparam int             CW        = cnt_width(FILT_CNT);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(FILT_CNT - 1);
  localparam logic           LVL_INACT = inactive_level(ACTIVE_LEVEL);
  localparam logic           LVL_ACT   = ~LVL_INACT;

  if (SYNCSTAGE < SYNC_MIN || SYNCSTAGE > SYNC_MAX ||
      FILT_CNT < FILT_MIN || FILT_CNT > FILT_MAX) begin : g_param_err
    $error("cdclib_lvlsync_filt_ch: illegal SYNCSTAGE or FILT_CNT");
  end

  logic [SYNCSTAGE-1:0] sync_q, sync_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 lvl_q, lvl_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic                 sync_last;

  assign sync_last = sync_q[SYNCSTAGE-1];

  always_comb begin
    sync_d = {sync_q[SYNCSTAGE-2:0], data_in};
    cnt_d  = cnt_q;
    lvl_d  = lvl_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync_last == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      lvl_d  = sync_last;
      cnt_d  = '0;
      rise_d = (sync_last == LVL_ACT);
      fall_d = (sync_last == LVL_INACT);
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      sync_q <= {SYNCSTAGE{LVL_INACT}};
      cnt_q  <= '0;
      lvl_q  <= LVL_INACT;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign data_lvl = lvl_q;
  assign rise_pls = rise_q;
  assign fall_pls = fall_q;

  if (EN_PULSE_MODE != 0) begin : g_pulse_out
    assign data_out = rise_q | fall_q;
  end else begin : g_level_out
    assign data_out = lvl_q;
  end

`ifdef CDCLIB_LVLSYNC_STICKY_EN
  logic sticky_q, sticky_d;

  // A strobe arriving with a clear keeps the flag set so no change is lost.
  always_comb begin
    sticky_d = sticky_q;
    if (rise_q || fall_q) begin
      sticky_d = 1'b1;
    end else if (sticky_clr) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign chg_sticky = sticky_q;
`endif

endmodule
`default_nettype wire

// File: rtl/cdclib_lvlsync_filt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cdclib_lvlsync_filt : multi-channel filtered level synchroniser (top).
// Optional sticky change flags under CDCLIB_LVLSYNC_STICKY_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module cdclib_lvlsync_filt
  import cdclib_lvlsync_pkg::*;
#(
  parameter int NUM_CH        = 1,
  parameter int SYNCSTAGE     = 2,
  parameter int FILT_CNT      = 4,
  parameter int ACTIVE_LEVEL  = 1,
  parameter int EN_PULSE_MODE = 0
) (
  input  logic              rd_clk,
  input  logic              rd_rst_n,
  input  logic [NUM_CH-1:0] data_in,
`ifdef CDCLIB_LVLSYNC_STICKY_EN
  input  logic [NUM_CH-1:0] sticky_clr,
  output logic [NUM_CH-1:0] chg_sticky,
`endif
  output logic [NUM_CH-1:0] data_out,
  output logic [NUM_CH-1:0] data_lvl,
  output logic [NUM_CH-1:0] rise_pls,
  output logic [NUM_CH-1:0] fall_pls
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    cdclib_lvlsync_filt_ch #(
      .SYNCSTAGE    (SYNCSTAGE),
      .FILT_CNT     (FILT_CNT),
      .ACTIVE_LEVEL (ACTIVE_LEVEL),
      .EN_PULSE_MODE(EN_PULSE_MODE)
    ) u_ch (
      .rd_clk    (rd_clk),
      .rd_rst_n  (rd_rst_n),
      .data_in   (data_in[i]),
`ifdef CDCLIB_LVLSYNC_STICKY_EN
      .sticky_clr(sticky_clr[i]),
      .chg_sticky(chg_sticky[i]),
`endif
      .data_out  (data_out[i]),
      .data_lvl  (data_lvl[i]),
      .rise_pls  (rise_pls[i]),
      .fall_pls  (fall_pls[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_cdclib_lvlsync_filt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cdclib_lvlsync_filt : three configurations of the filtered level sync.
// Sticky-flag sequence only when CDCLIB_LVLSYNC_STICKY_EN is defined.
// ---------------------------------------------------------------------------
module tb_cdclib_lvlsync_filt;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A: S=2 F=4 active-high level; B: S=3 F=5 active-high level;
  // C: S=2 F=4 active-low pulse mode
  logic [1:0] din_a, din_b, din_c;
  logic [1:0] a_out, a_lvl, a_rise, a_fall;
  logic [1:0] b_out, b_lvl, b_rise, b_fall;
  logic [1:0] c_out, c_lvl, c_rise, c_fall;
`ifdef CDCLIB_LVLSYNC_STICKY_EN
  logic [1:0] clr_a, clr_b, clr_c;
  logic [1:0] stk_a, stk_b, stk_c;
`endif

  cdclib_lvlsync_filt #(.NUM_CH(2), .SYNCSTAGE(2), .FILT_CNT(4),
                        .ACTIVE_LEVEL(1), .EN_PULSE_MODE(0)) u_dut_a (
    .rd_clk(clk), .rd_rst_n(rst_n), .data_in(din_a),
`ifdef CDCLIB_LVLSYNC_STICKY_EN
    .sticky_clr(clr_a), .chg_sticky(stk_a),
`endif
    .data_out(a_out), .data_lvl(a_lvl), .rise_pls(a_rise), .fall_pls(a_fall));

  cdclib_lvlsync_filt #(.NUM_CH(2), .SYNCSTAGE(3), .FILT_CNT(5),
                        .ACTIVE_LEVEL(1), .EN_PULSE_MODE(0)) u_dut_b (
    .rd_clk(clk), .rd_rst_n(rst_n), .data_in(din_b),
`ifdef CDCLIB_LVLSYNC_STICKY_EN
    .sticky_clr(clr_b), .chg_sticky(stk_b),
`endif
    .data_out(b_out), .data_lvl(b_lvl), .rise_pls(b_rise), .fall_pls(b_fall));

  cdclib_lvlsync_filt #(.NUM_CH(2), .SYNCSTAGE(2), .FILT_CNT(4),
                        .ACTIVE_LEVEL(0), .EN_PULSE_MODE(1)) u_dut_c (
    .rd_clk(clk), .rd_rst_n(rst_n), .data_in(din_c),
`ifdef CDCLIB_LVLSYNC_STICKY_EN
    .sticky_clr(clr_c), .chg_sticky(stk_c),
`endif
    .data_out(c_out), .data_lvl(c_lvl), .rise_pls(c_rise), .fall_pls(c_fall));

  typedef struct {
    int    edge_no;
    int    dut;
    int    ch;
    logic [3:0] exp;   // {data_out, data_lvl, rise_pls, fall_pls}
    string nm;
  } chk_t;

  typedef struct {
    int   dut;
    int   ch;
    logic val;
    int   width;   // 0: level held
    logic pass;    // expected to reach data_lvl
  } vec_t;

  chk_t sb[$];
  vec_t vecs[10];
  logic lvl_exp[3][2];
  logic [3:0] mon_act;

  function automatic int lat_of(input int d);
    return (d == 1) ? 8 : 6;
  endfunction

  function automatic logic act_of(input int d);
    return (d == 2) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [3:0] sample(input int d, input int c);
    case (d)
      0:       return {a_out[c], a_lvl[c], a_rise[c], a_fall[c]};
      1:       return {b_out[c], b_lvl[c], b_rise[c], b_fall[c]};
      default: return {c_out[c], c_lvl[c], c_rise[c], c_fall[c]};
    endcase
  endfunction

  task automatic push(input int e, input int d, input int c,
                      input logic lvl, input logic r, input logic f, input string nm);
    chk_t t;
    t.edge_no = e;
    t.dut     = d;
    t.ch      = c;
    t.exp     = {(d == 2) ? (r | f) : lvl, lvl, r, f};
    t.nm      = nm;
    sb.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b required %b", nm, act, exp);
    end
  endtask

  task automatic set_din(input int d, input int c, input logic v);
    case (d)
      0:       din_a[c] = v;
      1:       din_b[c] = v;
      default: din_c[c] = v;
    endcase
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].edge_no == cyc) begin
        mon_act = sample(sb[i].dut, sb[i].ch);
        n_cmp++;
        if (mon_act !== sb[i].exp) begin
          n_bad++;
          $display("FAIL %s dut%0d ch%0d edge %0d: got out/lvl/rise/fall=%b required %b",
                   sb[i].nm, sb[i].dut, sb[i].ch, cyc, mon_act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int   k, l, d, c;
    logic old, nw, a;
    d   = v.dut;
    c   = v.ch;
    l   = lat_of(d);
    a   = act_of(d);
    old = lvl_exp[d][c];
    nw  = v.val;
    @(negedge clk);
    k = cyc;
    set_din(d, c, nw);
    if (v.pass) begin
      push(k + l - 1, d, c, old, 1'b0, 1'b0, $sformatf("v%0d_pre", idx));
      push(k + l,     d, c, nw, nw == a, nw != a, $sformatf("v%0d_edge", idx));
      push(k + l + 1, d, c, nw, 1'b0, 1'b0, $sformatf("v%0d_post", idx));
      push(k + l, d, 1 - c, lvl_exp[d][1 - c], 1'b0, 1'b0, $sformatf("v%0d_other", idx));
    end else begin
      push(k + l, d, c, old, 1'b0, 1'b0, $sformatf("v%0d_glitch", idx));
    end
    if (v.width > 0) begin
      repeat (v.width) @(negedge clk);
      k = k + v.width;
      set_din(d, c, old);
      if (v.pass) begin
        push(k + l - 1, d, c, nw, 1'b0, 1'b0, $sformatf("v%0d_back_pre", idx));
        push(k + l,     d, c, old, old == a, old != a, $sformatf("v%0d_back_edge", idx));
        push(k + l + 1, d, c, old, 1'b0, 1'b0, $sformatf("v%0d_back_post", idx));
      end else begin
        push(k + l, d, c, old, 1'b0, 1'b0, $sformatf("v%0d_back_glitch", idx));
      end
    end else if (v.pass) begin
      lvl_exp[d][c] = nw;
    end
    repeat (l + 4) @(negedge clk);
  endtask

  initial begin
    int r, k;
    vecs[0] = '{dut: 0, ch: 0, val: 1'b1, width: 3, pass: 1'b0};
    vecs[1] = '{dut: 0, ch: 0, val: 1'b1, width: 4, pass: 1'b1};
    vecs[2] = '{dut: 0, ch: 0, val: 1'b1, width: 6, pass: 1'b1};
    vecs[3] = '{dut: 0, ch: 1, val: 1'b1, width: 8, pass: 1'b1};
    vecs[4] = '{dut: 0, ch: 0, val: 1'b1, width: 1, pass: 1'b0};
    vecs[5] = '{dut: 1, ch: 0, val: 1'b1, width: 0, pass: 1'b1};
    vecs[6] = '{dut: 2, ch: 0, val: 1'b0, width: 0, pass: 1'b1};
    vecs[7] = '{dut: 2, ch: 0, val: 1'b1, width: 0, pass: 1'b1};
    vecs[8] = '{dut: 1, ch: 0, val: 1'b0, width: 2, pass: 1'b0};
    vecs[9] = '{dut: 1, ch: 0, val: 1'b0, width: 0, pass: 1'b1};
    lvl_exp[0][0] = 1'b0; lvl_exp[0][1] = 1'b0;
    lvl_exp[1][0] = 1'b0; lvl_exp[1][1] = 1'b0;
    lvl_exp[2][0] = 1'b1; lvl_exp[2][1] = 1'b1;

    rst_n = 1'b0;
    din_a = 2'b11;
    din_b = 2'b00;
    din_c = 2'b11;
`ifdef CDCLIB_LVLSYNC_STICKY_EN
    clr_a = 2'b00; clr_b = 2'b00; clr_c = 2'b00;
`endif
    repeat (4) @(negedge clk);
    chk("rst_a_lvl",  {2'b00, a_lvl},  4'b0000);
    chk("rst_a_rise", {2'b00, a_rise}, 4'b0000);
    chk("rst_a_fall", {2'b00, a_fall}, 4'b0000);
    chk("rst_a_out",  {2'b00, a_out},  4'b0000);
    chk("rst_c_lvl",  {2'b00, c_lvl},  4'b0011);
    chk("rst_c_out",  {2'b00, c_out},  4'b0000);
`ifdef CDCLIB_LVLSYNC_STICKY_EN
    chk("rst_a_sticky", {2'b00, stk_a}, 4'b0000);
`endif

    // Inputs already active at release must still wait out the full latency.
    rst_n = 1'b1;
    r = cyc;
    for (int c = 0; c < 2; c++) begin
      push(r + 5, 0, c, 1'b0, 1'b0, 1'b0, "rel_pre");
      push(r + 6, 0, c, 1'b1, 1'b1, 1'b0, "rel_rise");
      push(r + 7, 0, c, 1'b1, 1'b0, 1'b0, "rel_post");
    end
    repeat (10) @(negedge clk);
    k = cyc;
    din_a = 2'b00;
    for (int c = 0; c < 2; c++) begin
      push(k + 5, 0, c, 1'b1, 1'b0, 1'b0, "rel_fall_pre");
      push(k + 6, 0, c, 1'b0, 1'b0, 1'b1, "rel_fall");
    end
    repeat (10) @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Reset lands with the dut A ch0 filter count at FILT_CNT-2.
    @(negedge clk);
    k = cyc;
    din_a[0] = 1'b1;
    push(k + 6, 0, 0, 1'b0, 1'b0, 1'b0, "rstmid_nofire");
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    push(r + 5, 0, 0, 1'b0, 1'b0, 1'b0, "rstmid_pre");
    push(r + 6, 0, 0, 1'b1, 1'b1, 1'b0, "rstmid_rise");
    push(r + 7, 0, 0, 1'b1, 1'b0, 1'b0, "rstmid_post");
    repeat (12) @(negedge clk);

`ifdef CDCLIB_LVLSYNC_STICKY_EN
    clr_a[1] = 1'b1;
    @(negedge clk);
    chk("stk_pre_clear", {3'b000, stk_a[1]}, 4'b0000);
    clr_a[1] = 1'b0;
    k = cyc;
    din_a[1] = 1'b1;
    repeat (6) @(negedge clk);
    chk("stk_rise_seen", {3'b000, a_rise[1]}, 4'b0001);
    clr_a[1] = 1'b1;
    @(negedge clk);
    chk("stk_set_wins", {3'b000, stk_a[1]}, 4'b0001);
    @(negedge clk);
    chk("stk_clear", {3'b000, stk_a[1]}, 4'b0000);
    clr_a[1] = 1'b0;
    repeat (4) @(negedge clk);
`endif

    repeat (20) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending checks required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
